pc_fetch_predictor: RTL
=======================

Name: pc_fetch_predictor

Overview:
- Fetch-stage program counter with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Each cycle, a combinational BTB lookup on the current PC picks the next PC: predicted target or PC+4.
- Execute stage supplies mispredict/JALR redirects and resolved-branch training updates.
- Replaces the fixed, non-predicting PC register in the pipelined core.

Parameters:
- DATA_WIDTH, 32, PC/address width.
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- BTB_ENTRIES, 16, BTB depth; power of two, >=2.
- Derived localparams, not overridable: IDX_W = $clog2(BTB_ENTRIES); TAG_W = DATA_WIDTH-2-IDX_W.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  fetch advance; 0 = stall (hold PC)
- redirect_valid  in  1  execute-stage redirect (mispredict or JALR)
- redirect_pc  in  DATA_WIDTH  redirect address; bits[1:0] forced to 0
- upd_valid  in  1  training update from a resolved branch/jump
- upd_pc  in  DATA_WIDTH  PC of resolved instruction
- upd_target  in  DATA_WIDTH  resolved target; bits[1:0] forced to 0
- upd_taken  in  1  resolved direction
- pcf  out  DATA_WIDTH  current fetch PC
- pcplus4f  out  DATA_WIDTH  pcf+4, modulo 2^DATA_WIDTH
- pred_taken_f  out  1  BTB predicts taken for pcf
- pred_target_f  out  DATA_WIDTH  predicted next PC for pcf

Behaviour:
- Index and tag: idx = pc[IDX_W+1:2], tag = pc[DATA_WIDTH-1:IDX_W+2].
- Each BTB entry holds: valid, tag, target, ctr[1:0].
- Lookup (combinational on pcf):
  - hit = valid[idx] && tag match.
  - pred_taken_f = hit && ctr[1].
  - pred_target_f = pred_taken_f ? target : pcplus4f.
- Next-PC priority at posedge clk, highest first:
  1. reset -> RESET_VECTOR.
  2. redirect_valid -> {redirect_pc[DATA_WIDTH-1:2],2'b00}, applied even when enable=0.
  3. enable -> pred_target_f.
  4. Otherwise hold.
- Training on upd_valid at posedge, independent of enable and redirect:
  - Hit, taken: ctr saturating increment (max 2'b11); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite entry (valid=1, new tag, target=upd_target, ctr=2'b10 weakly taken).
  - Miss, not taken: no change.
- Read-before-write: a lookup and an update to the same index in one cycle returns pre-update contents; the update is visible from the next cycle.
- Reset, including mid-operation: pcf=RESET_VECTOR; all valid bits cleared; ctr=2'b01; targets/tags don't-care.
  - Outputs after reset: pcplus4f=RESET_VECTOR+4, pred_taken_f=0, pred_target_f=RESET_VECTOR+4.
  - Updates are ignored in a reset cycle.
- Latency: redirect/prediction visible on pcf one cycle after the edge; update affects predictions one cycle after its edge.
- Wrap-around: 32'hFFFFFFFC + 4 = 32'h00000000; no flag.
- Misprediction detection is external; this block only consumes redirect_valid.

Decomposition:
- Package pc_pkg:
  - RESET_VECTOR default.
  - ctr_t 2-bit typedef with encodings SNT=00, WNT=01, WT=10, ST=11.
  - btb_entry_t packed struct {valid, tag, target, ctr}, parametrised by width via localparams.
  - Saturating-increment/decrement functions.
- Sub-module branch_target_buffer:
  - Storage, combinational lookup port, synchronous update port, reset clear.
- pc_fetch_predictor holds the PC register and next-PC mux.

Test Plan:
- Sequential fetch: reset 1 cycle, enable=1 -> pcf BFC00000, BFC00004, BFC00008; pred_taken_f=0 throughout. enable=0 for 3 cycles -> pcf holds BFC00008.
- Redirect during stall: enable=0, redirect_valid=1, redirect_pc=80000103 -> next pcf=80000100. Then redirect_pc=FFFFFFFC, enable=1 -> pcf FFFFFFFC then 00000000.
- Allocate and predict: upd_valid, upd_pc=BFC00008, upd_target=BFC00100, taken. Then reset PC only via redirect to BFC00000, run -> at pcf=BFC00008 pred_taken_f=1, next pcf=BFC00100.
- Counter hysteresis on the entry above (ctr=10):
  - Not-taken update -> 01, predicts not-taken (next pcf BFC0000C).
  - Second not-taken -> 00.
  - Two taken updates -> 10, predicts taken again.
- Aliasing (16 entries): taken update upd_pc=BFC00048 (idx 2, different tag), target BFC00200 -> lookup at BFC00008 misses (pred_target_f=BFC0000C); lookup at BFC00048 hits to BFC00200.
- Simultaneous events:
  - Update and lookup on the same idx in one cycle -> prediction uses old entry.
  - redirect_valid+enable+predicted-taken -> redirect wins.
  - reset asserted mid-run with valid entries -> pcf=BFC00000, pred_taken_f=0 at BFC00008.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the fetch-stage PC and branch target buffer.
//   RESET_VECTOR_DEFAULT : default PC after reset.
//   ctr_t                : 2-bit direction counter (SNT/WNT/WT/ST).
//   btb_entry_t          : one BTB entry in the default 32-bit, 16-entry configuration.
//   ctr_inc / ctr_dec    : saturating counter steps.
package pc_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam int PC_W        = 32;
  localparam int BTB_DEPTH   = 16;
  localparam int BTB_IDX_W   = $clog2(BTB_DEPTH);
  localparam int BTB_TAG_W   = PC_W - 2 - BTB_IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_fetch_predictor_branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters.
//   clk, reset        : clock, synchronous active-high reset (clears valid, ctr -> WNT)
//   lookup_pc         : PC looked up combinationally
//   lookup_hit        : valid entry with matching tag
//   lookup_taken      : hit and counter MSB set
//   lookup_target     : stored target of the indexed entry
//   upd_valid/upd_pc/upd_target/upd_taken : training port, written at posedge
// Lookup reads the arrays directly, so an update in the same cycle is seen
// only from the following cycle.
module branch_target_buffer
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  lookup_hit,
  output logic                  lookup_taken,
  output logic [DATA_WIDTH-1:0] lookup_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_reg;
  ctr_t                   ctr_reg    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_reg    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_reg [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             up_alloc;
  logic [DATA_WIDTH-1:0] up_target_aligned;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[DATA_WIDTH-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[DATA_WIDTH-1:IDX_W+2];
  assign up_target_aligned = {upd_target[DATA_WIDTH-1:2], 2'b00};

  assign lookup_hit    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign lookup_taken  = lookup_hit && ctr_reg[lk_idx][1];
  assign lookup_target = target_reg[lk_idx];

  assign up_hit   = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
  // Taken updates always write tag/target: a hit refreshes the target,
  // a miss allocates (or steals) the slot.
  assign up_alloc = upd_valid && !reset && upd_taken;

  always_ff @(posedge clk) begin
    if (up_alloc) begin
      tag_reg[up_idx]    <= up_tag;
      target_reg[up_idx] <= up_target_aligned;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          ctr_reg[gi]   <= WNT;
        end else if (upd_valid && (up_idx == IDX_W'(gi))) begin
          if (up_hit) begin
            ctr_reg[gi] <= upd_taken ? ctr_inc(ctr_reg[gi]) : ctr_dec(ctr_reg[gi]);
          end else if (upd_taken) begin
            valid_reg[gi] <= 1'b1;
            ctr_reg[gi]   <= WT;
          end
        end
      end
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: rtl/pc_fetch_predictor.sv
// pc_fetch_predictor: fetch PC register with BTB-driven next-PC selection.
//   clk, reset      : clock, synchronous active-high reset (PC -> RESET_VECTOR)
//   enable          : advance fetch; 0 holds the PC
//   redirect_valid/redirect_pc : execute-stage redirect, wins over enable
//   upd_*           : BTB training from resolved branches/jumps
//   pcf, pcplus4f   : current fetch PC and PC+4 (wraps)
//   pred_taken_f, pred_target_f : prediction for pcf
module pc_fetch_predictor
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(RESET_VECTOR_DEFAULT),
  parameter int                    BTB_ENTRIES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  output logic [DATA_WIDTH-1:0] pcf,
  output logic [DATA_WIDTH-1:0] pcplus4f,
  output logic                  pred_taken_f,
  output logic [DATA_WIDTH-1:0] pred_target_f
);

  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic                  btb_hit;
  logic                  btb_taken;
  logic [DATA_WIDTH-1:0] btb_target;

  branch_target_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc    (pc_reg),
    .lookup_hit   (btb_hit),
    .lookup_taken (btb_taken),
    .lookup_target(btb_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken)
  );

  assign pcf           = pc_reg;
  assign pcplus4f      = pc_reg + DATA_WIDTH'(4);
  assign pred_taken_f  = btb_taken;
  assign pred_target_f = btb_taken ? btb_target : pcplus4f;

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (enable) begin
      pc_next = pred_target_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], btb_hit};

endmodule
